adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_ctrl_pkg.sv | 14 +
 rtl/adder_seq_ctrl_if.sv | 30 +++
 rtl/adder_seq_ctrl_adder_4bit.sv | 25 ++
 rtl/adder_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the controller state encoding and the slice width (NIBBLE).
// The state values are fixed: IDLE=0, RUN=1, DONE=2.
package adder_seq_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Handshake bundle between the ALU issue logic, the sequencer and the result bus.
//   Request side : in_valid, in_ready, a, b, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf, zero
// The master modport is the issue/consumer side.
// The slave modport is the sequencer.
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_seq_ctrl_adder_4bit.sv
// The one shared 4-bit ripple-carry adder slice. It is purely combinational.
//   a, b : nibble operands
//   c0   : carry in
//   s    : nibble sum
//   co   : carry out of the top bit
module adder_seq_ctrl_adder_4bit
    import adder_seq_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              c0,
    output logic [NIBBLE-1:0] s,
    output logic              co
);
    logic [NIBBLE:0] c;

    assign c[0] = c0;

    for (genvar gi = 0; gi < NIBBLE; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co = c[NIBBLE];
endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer.
// One 4-bit slice is stepped over the operand nibbles, LSB first, one nibble per clock.
// The carry between nibbles is held in carry_reg.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of adder_seq_ctrl_if
// in_ready is a decode of the state register. Every other output is registered.
// Subtract is done as a + ~b + 1. opb_reg therefore holds the inverted operand,
// and the ovf rule compares against that inverted operand.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SLICES = WIDTH / NIBBLE
) (
    input  logic               clk,
    input  logic               rst,
    adder_seq_ctrl_if.slave    bus
);
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   opa_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               zero_reg;
    logic               out_valid_reg;

    // Nibble views of the operands, so that idx_reg can select one nibble.
    logic [NIBBLE-1:0]  opa_nib [SLICES];
    logic [NIBBLE-1:0]  opb_nib [SLICES];
    logic [NIBBLE-1:0]  slice_a;
    logic [NIBBLE-1:0]  slice_b;
    logic [NIBBLE-1:0]  slice_sum;
    logic               slice_co;
    logic [WIDTH-1:0]   sum_next;
    logic               ovf_next;

    // sum_next is sum_reg with the current nibble replaced by the slice result.
    // On the final RUN edge it is the complete result.
    // The flags are taken from it so that they register together with the last nibble.
    for (genvar gi = 0; gi < SLICES; gi++) begin : g_nib
        assign opa_nib[gi] = opa_reg[gi*NIBBLE +: NIBBLE];
        assign opb_nib[gi] = opb_reg[gi*NIBBLE +: NIBBLE];
        assign sum_next[gi*NIBBLE +: NIBBLE] =
            (idx_reg == IDX_W'(gi)) ? slice_sum : sum_reg[gi*NIBBLE +: NIBBLE];
    end

    assign slice_a = opa_nib[idx_reg];
    assign slice_b = opb_nib[idx_reg];

    adder_seq_ctrl_adder_4bit u_adder_4bit (
        .a  (slice_a),
        .b  (slice_b),
        .c0 (carry_reg),
        .s  (slice_sum),
        .co (slice_co)
    );

    assign ovf_next = (opa_reg[WIDTH-1] == opb_reg[WIDTH-1]) &&
                      (sum_next[WIDTH-1] != opa_reg[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            opa_reg       <= '0;
            opb_reg       <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_reg   <= bus.a;
                        opb_reg   <= bus.b ^ {WIDTH{bus.sub}};
                        carry_reg <= bus.sub;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_co;
                    if (idx_reg == LAST_IDX) begin
                        // The top carry goes only to cout. No result bits are kept beyond WIDTH.
                        idx_reg       <= '0;
                        cout_reg      <= slice_co;
                        ovf_reg       <= ovf_next;
                        zero_reg      <= (sum_next == '0);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl at WIDTH=16.
// Results are pushed to a scoreboard queue when a request is issued.
// They are popped when out_valid is seen.
module tb_adder_seq_ctrl;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_seq_ctrl_if #(.WIDTH(W)) bus ();

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb [$];

    // Independent full-width reference: the carry is bit W of the wide sum.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] wide;
        res_t r;
        if (sub) wide = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else     wide = {1'b0, a} + {1'b0, b};
        r.sum  = wide[W-1:0];
        r.cout = wide[W];
        if (sub) r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        else     r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.sum, bus.cout, bus.ovf, bus.zero};
    endfunction

    // Wait for in_ready, present one request and release in_valid after the accept edge.
    // Returns with time at accept edge + 1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input res_t exp);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(exp);
    endtask

    // Count edges after the accept edge until out_valid, with a bound.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // Issue one operation and compare its result and latency.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input res_t exp);
        int   lat;
        res_t e;
        res_t o;
        send(a, b, sub, exp);
        wait_out(lat);
        e = sb.pop_front();
        o = observed();
        $display("%s: a=%h b=%h sub=%0b -> sum=%h cout=%0b ovf=%0b zero=%0b lat=%0d",
                 name, a, b, sub, o.sum, o.cout, o.ovf, o.zero, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required 4", name, lat);
        end
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s_result: got sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                     name, o.sum, o.cout, o.ovf, o.zero, e.sum, e.cout, e.ovf, e.zero);
        end
        handshake_out();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: in_ready=%0b out_valid=%0b required 1/0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: in_ready=%0b out_valid=%0b sum=%h", bus.in_ready, bus.out_valid, bus.sum);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== {2'b10, 16'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b vld=%0b sum=%h c=%0b v=%0b z=%0b required 1 0 0000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_add_basic();
        run_op("add_basic", 16'h1234, 16'h0FED, 1'b0, '{sum:16'h2221, cout:1'b0, ovf:1'b0, zero:1'b0});
    endtask

    task automatic test_carry_ripple();
        run_op("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, '{sum:16'h0000, cout:1'b1, ovf:1'b0, zero:1'b1});
    endtask

    task automatic test_overflow();
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, '{sum:16'h8000, cout:1'b0, ovf:1'b1, zero:1'b0});
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, '{sum:16'h7FFF, cout:1'b1, ovf:1'b1, zero:1'b0});
    endtask

    task automatic test_sub_negative();
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, '{sum:16'hFFFE, cout:1'b0, ovf:1'b0, zero:1'b0});
    endtask

    task automatic test_backpressure();
        res_t e;
        int   errs_rdy = 0;
        int   errs_out = 0;
        send(16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0));
        e = sb.pop_front();
        // Junk requests arrive during RUN and DONE while out_ready is held low.
        for (int i = 1; i <= 14; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.sub = 1'($urandom);
            @(posedge clk); #1;
            if (bus.in_ready !== 1'b0) errs_rdy++;
            if (i >= 4 && (bus.out_valid !== 1'b1 || observed() !== e)) errs_out++;
        end
        bus.in_valid = 1'b0;
        $display("backpressure: sum=%h out_valid=%0b held 10+ cycles", bus.sum, bus.out_valid);
        n_checks++;
        if (errs_rdy != 0) begin
            n_fail++;
            $display("FAIL bp_in_ready: %0d cycles with in_ready high, required 0", errs_rdy);
        end
        n_checks++;
        if (errs_out != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, last sum=%h required %h", errs_out, bus.sum, e.sum);
        end
        handshake_out();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%0b required 1", bus.in_ready);
        end
        run_op("bp_next", 16'hA5A5, 16'h5A5B, 1'b0, '{sum:16'h0000, cout:1'b1, ovf:1'b0, zero:1'b1});
    endtask

    task automatic test_reset_midflight();
        send(16'h1234, 16'h1111, 1'b0, model(16'h1234, 16'h1111, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        $display("reset_mid: in_ready=%0b out_valid=%0b sum=%h", bus.in_ready, bus.out_valid, bus.sum);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%0b vld=%0b sum=%h required 1 0 0000",
                     bus.in_ready, bus.out_valid, bus.sum);
        end
        run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, '{sum:16'h0100, cout:1'b0, ovf:1'b0, zero:1'b0});
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = (i == 3) ? a : 16'($urandom);
            s = (i == 3) ? 1'b1 : 1'($urandom);
            run_op("b2b", a, b, s, model(a, b, s));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_overflow();
        test_sub_negative();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
